steak_renderer: RTL and testbench
=================================

// Module: steak_renderer
// PURPOSE
//  Downstream consumer of the steak doneness controller's colour_muscle/colour_fat.
//  Redraws the steak sprite into the 160x120, 9-bit-colour VGA frame buffer.
//  The sprite is a filled rectangle with a fat rim of FAT_BORDER pixels around a muscle interior.
//  It emits one pixel per clk as x/y/colour/plot, straight into the VGA adapter's write port.
//  It redraws only when a colour input changes or a redraw is requested.
// PARAMETERS
//  X0          60  left column of sprite (X0+WIDTH <= 160)
//  Y0          40  top row of sprite (Y0+HEIGHT <= 120)
//  WIDTH       40  sprite width in pixels, 2..160
//  HEIGHT      30  sprite height in pixels, 2..120
//  FAT_BORDER   3  rim thickness; 2*FAT_BORDER < min(WIDTH,HEIGHT)
// PORTS
//  clk            in   1  system clock
//  resetn         in   1  synchronous, active-low reset
//  colour_muscle  in   9  interior colour {R[2:0],G[2:0],B[2:0]} from controller
//  colour_fat     in   9  rim colour, same encoding
//  redraw         in   1  single-cycle request to force a full redraw
//  x              out  8  frame-buffer column
//  y              out  7  frame-buffer row
//  colour         out  9  pixel colour
//  plot           out  1  pixel write strobe to VGA adapter
//  busy           out  1  high from LOAD through DONE inclusive
//  done           out  1  one-cycle pulse after the last pixel of a frame
// BEHAVIOUR
//  Reset (clk edge with resetn=0):
//   - x, y, colour, plot, busy, done <= 0; state <= IDLE.
//   - snap_m, snap_f <= 0; cx, cy <= 0.
//   - redraw_req <= 1, so the first draw follows reset.
//  State machine IDLE -> LOAD -> DRAW -> DONE -> IDLE:
//   - change = ({colour_muscle,colour_fat} != {snap_m,snap_f}); evaluated every cycle.
//   - redraw_req: set by redraw=1 in any state; cleared only in LOAD (set wins same cycle).
//   - IDLE: go to LOAD if change or redraw_req or redraw; else stay.
//   - LOAD (1 cycle): snap_m/snap_f <= inputs; cx, cy <= 0; clear redraw_req.
//   - DRAW: one pixel per cycle, row-major; cx wraps WIDTH-1 -> 0 with cy++.
//     Leave for DONE on the cycle that issues pixel (WIDTH-1, HEIGHT-1).
//   - DONE (1 cycle): done=1, plot=0; next state IDLE.
//  Pixel outputs (registered, valid in the cycle plot=1):
//   - x = X0+cx, y = Y0+cy.
//   - colour = snap_f if cx<FAT_BORDER, cx>=WIDTH-FAT_BORDER, cy<FAT_BORDER or cy>=HEIGHT-FAT_BORDER.
//   - Otherwise colour = snap_m.
//  Timing:
//   - First plot=1 is 2 cycles after the IDLE cycle that sees the trigger.
//   - plot is high exactly WIDTH*HEIGHT consecutive cycles per frame; no gaps.
//   - done is high the cycle after the final plot.
//  Colours are snapshotted in LOAD; input changes during DRAW never tear a frame.
//  A mid-frame change leaves change=1, so IDLE re-enters LOAD right after DONE.
//  All-zero colours (steak nonexistent) are drawn like any other value, i.e. the sprite is blanked.
//  redraw during IDLE with no change still triggers a full frame.
//  Reset mid-DRAW: plot=0 on the next cycle; a full redraw follows via redraw_req.
//  Coordinate arithmetic is unsigned; parameters must keep X0+WIDTH and Y0+HEIGHT in range (no wrap).
// TESTING (WIDTH=6, HEIGHT=4, FAT_BORDER=1, X0=10, Y0=20 unless noted)
//  1 Release reset with inputs 0 -> frame: 24 plots of colour 0, (10,20)..(15,23) row-major.
//    Then done=1 for 1 cycle, then idle with plot=0.
//  2 Set muscle=9'h1C0, fat=9'h1FF -> first plot 2 cycles after IDLE sees it; (10,20)=1FF, (11,21)=1C0.
//    (14,22)=1C0, (15,22)=1FF; exactly 8 muscle pixels.
//  3 Change muscle to 9'h124 at pixel 10 of a frame -> current frame stays 1C0 interior.
//    Second frame starts right after done, with interior 124.
//  4 Hold inputs, pulse redraw in IDLE -> one identical frame; pulse redraw during DRAW -> exactly one extra frame.
//  5 Assert resetn=0 at pixel 5 -> plot=0 next cycle; after release a full 24-pixel frame is drawn.
//  6 Defaults (40x30, border 3) -> 1200 plots; last pixel (99,69); interior count 34*24=816.

Source files
------------

// File: rtl/steak_renderer_if.sv
// Pixel-write bus between the steak renderer and the VGA adapter, plus the
// colour/redraw inputs it receives from the doneness controller.
interface steak_renderer_if;
    logic [8:0] colour_muscle;
    logic [8:0] colour_fat;
    logic       redraw;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        input  colour_muscle, colour_fat, redraw,
        output x, y, colour, plot, busy, done
    );

    modport slave (
        output colour_muscle, colour_fat, redraw,
        input  x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/steak_renderer.sv
// Redraws the steak sprite (fat rim around a muscle interior) into the VGA
// frame buffer one pixel per clock, only when the colours change or on request.
module steak_renderer #(
    parameter int unsigned X0         = 60,
    parameter int unsigned Y0         = 40,
    parameter int unsigned WIDTH      = 40,
    parameter int unsigned HEIGHT     = 30,
    parameter int unsigned FAT_BORDER = 3
) (
    input  logic             clk,
    input  logic             resetn,
    steak_renderer_if.master vga
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] X0_C    = 8'(X0);
    localparam logic [7:0] CX_LAST = 8'(WIDTH - 1);
    localparam logic [7:0] FB_X    = 8'(FAT_BORDER);
    localparam logic [7:0] FX_HI   = 8'(WIDTH - FAT_BORDER);
    localparam logic [6:0] Y0_C    = 7'(Y0);
    localparam logic [6:0] CY_LAST = 7'(HEIGHT - 1);
    localparam logic [6:0] FB_Y    = 7'(FAT_BORDER);
    localparam logic [6:0] FY_HI   = 7'(HEIGHT - FAT_BORDER);

    function automatic logic [8:0] pick_colour(input logic [7:0] px, input logic [6:0] py,
                                               input logic [8:0] m, input logic [8:0] f);
        if (px < FB_X || px >= FX_HI || py < FB_Y || py >= FY_HI) begin
            return f;
        end else begin
            return m;
        end
    endfunction

    logic [1:0] state_q, state_d;
    logic [8:0] snap_m_q, snap_m_d, snap_f_q, snap_f_d;
    logic [7:0] cx_q, cx_d, nx_s;
    logic [6:0] cy_q, cy_d, ny_s;
    logic       redraw_req_q, redraw_req_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [8:0] colour_q, colour_d;
    logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic       change_s;

    assign change_s = ({vga.colour_muscle, vga.colour_fat} != {snap_m_q, snap_f_q});

    // Next-state and next-pixel logic; outputs are registered so that plot
    // is high in the same cycle the FSM is in DRAW.
    always_comb begin
        state_d      = state_q;
        snap_m_d     = snap_m_q;
        snap_f_d     = snap_f_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        redraw_req_d = redraw_req_q | vga.redraw;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        done_d       = 1'b0;
        nx_s         = (cx_q == CX_LAST) ? 8'd0 : cx_q + 8'd1;
        ny_s         = (cx_q == CX_LAST) ? cy_q + 7'd1 : cy_q;
        case (state_q)
            ST_IDLE: begin
                if (change_s || redraw_req_q || vga.redraw) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                snap_m_d     = vga.colour_muscle;
                snap_f_d     = vga.colour_fat;
                cx_d         = 8'd0;
                cy_d         = 7'd0;
                redraw_req_d = vga.redraw;
                state_d      = ST_DRAW;
                plot_d       = 1'b1;
                x_d          = X0_C;
                y_d          = Y0_C;
                colour_d     = pick_colour(8'd0, 7'd0, vga.colour_muscle, vga.colour_fat);
            end
            ST_DRAW: begin
                if (cx_q == CX_LAST && cy_q == CY_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cx_d     = nx_s;
                    cy_d     = ny_s;
                    plot_d   = 1'b1;
                    x_d      = X0_C + nx_s;
                    y_d      = Y0_C + ny_s;
                    colour_d = pick_colour(nx_s, ny_s, snap_m_q, snap_f_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, snapshot and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            snap_m_q     <= 9'd0;
            snap_f_q     <= 9'd0;
            cx_q         <= 8'd0;
            cy_q         <= 7'd0;
            redraw_req_q <= 1'b1;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 9'd0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_m_q     <= snap_m_d;
            snap_f_q     <= snap_f_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            redraw_req_q <= redraw_req_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign vga.x      = x_q;
    assign vga.y      = y_q;
    assign vga.colour = colour_q;
    assign vga.plot   = plot_q;
    assign vga.busy   = busy_q;
    assign vga.done   = done_q;

endmodule

// File: tb/tb_steak_renderer.sv
// Directed bench: a 6x4 sprite (border 1 at 10,20) checked pixel by pixel,
// plus a default-sized instance checked for frame size, interior count and last pixel.
module tb_steak_renderer;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_err    = 0;
    // 6x4 sprite, bit i = pixel cy*6+cx; interior is cx 1..4 on rows 1..2
    logic [23:0] fat_mask = 24'hFE187F;

    steak_renderer_if va();
    steak_renderer_if vb();

    steak_renderer #(.X0(10), .Y0(20), .WIDTH(6), .HEIGHT(4), .FAT_BORDER(1)) dut_a (
        .clk(clk), .resetn(resetn), .vga(va)
    );
    steak_renderer dut_b (
        .clk(clk), .resetn(resetn), .vga(vb)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_plot(input string tag, input int exp_lat);
        int n = 0;
        while (va.plot !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, exp_lat);
    endtask

    task automatic pulse_redraw();
        va.redraw = 1'b1;
        @(negedge clk);
        va.redraw = 1'b0;
    endtask

    // Starts at the negedge showing pixel 0; ends at the negedge after done.
    task automatic check_frame(input string tag, input logic [8:0] m, input logic [8:0] f,
                               input int chg_idx, input logic [8:0] chg_val, input int rdr_idx);
        int muscle_n = 0;
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("%s px%0d plot", tag, i), va.plot, 1);
            chk($sformatf("%s px%0d x", tag, i), va.x, 10 + i % 6);
            chk($sformatf("%s px%0d y", tag, i), va.y, 20 + i / 6);
            chk($sformatf("%s px%0d colour", tag, i), va.colour, fat_mask[i] ? f : m);
            chk($sformatf("%s px%0d busy", tag, i), va.busy, 1);
            if (va.colour === m) muscle_n++;
            if (i == chg_idx) va.colour_muscle = chg_val;
            va.redraw = (i == rdr_idx);
            @(negedge clk);
        end
        va.redraw = 1'b0;
        chk({tag, " muscle count"}, muscle_n, (m == f) ? 24 : 8);
        chk({tag, " done"}, va.done, 1);
        chk({tag, " plot in done"}, va.plot, 0);
        chk({tag, " busy in done"}, va.busy, 1);
        @(negedge clk);
        chk({tag, " done cleared"}, va.done, 0);
        chk({tag, " idle plot"}, va.plot, 0);
        chk({tag, " idle busy"}, va.busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        int stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (va.plot !== 1'b0) stray++;
        end
        chk({tag, " stray plots"}, stray, 0);
    endtask

    initial begin
        int n;
        int cyc;
        int plots;
        int interior;
        int first_lat;
        int gaps;
        int seen_done;
        logic [7:0] first_x, last_x;
        logic [6:0] first_y, last_y;

        resetn           = 1'b0;
        va.colour_muscle = 9'h000;
        va.colour_fat    = 9'h000;
        va.redraw        = 1'b0;
        vb.colour_muscle = 9'h0AA;
        vb.colour_fat    = 9'h155;
        vb.redraw        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst x", va.x, 0);
        chk("rst y", va.y, 0);
        chk("rst colour", va.colour, 0);
        chk("rst plot", va.plot, 0);
        chk("rst busy", va.busy, 0);
        chk("rst done", va.done, 0);
        chk("rst b plot", vb.plot, 0);

        // 1: first frame after reset, all-zero colours
        resetn = 1'b1;
        wait_plot("t1", 2);
        check_frame("t1", 9'h000, 9'h000, -1, 9'h000, -1);

        // 2: colour change triggers a frame
        va.colour_muscle = 9'h1C0;
        va.colour_fat    = 9'h1FF;
        wait_plot("t2", 2);
        check_frame("t2", 9'h1C0, 9'h1FF, -1, 9'h000, -1);

        // 3: mid-frame colour change does not tear, next frame follows
        pulse_redraw();
        wait_plot("t3a", 1);
        check_frame("t3a", 9'h1C0, 9'h1FF, 10, 9'h124, -1);
        wait_plot("t3b", 2);
        check_frame("t3b", 9'h124, 9'h1FF, -1, 9'h000, -1);
        check_quiet("t3");

        // 4: redraw in IDLE, then redraw during DRAW yields exactly one extra frame
        pulse_redraw();
        wait_plot("t4a", 1);
        check_frame("t4a", 9'h124, 9'h1FF, -1, 9'h000, -1);
        check_quiet("t4a");
        pulse_redraw();
        wait_plot("t4b", 1);
        check_frame("t4b", 9'h124, 9'h1FF, -1, 9'h000, 7);
        wait_plot("t4c", 2);
        check_frame("t4c", 9'h124, 9'h1FF, -1, 9'h000, -1);
        check_quiet("t4c");

        // 5: reset mid-frame, full redraw after release
        pulse_redraw();
        wait_plot("t5a", 1);
        repeat (5) @(negedge clk);
        chk("t5 px5 x", va.x, 15);
        resetn = 1'b0;
        @(negedge clk);
        chk("t5 plot after reset", va.plot, 0);
        chk("t5 busy after reset", va.busy, 0);
        resetn = 1'b1;
        wait_plot("t5b", 2);
        check_frame("t5b", 9'h124, 9'h1FF, -1, 9'h000, -1);

        // 6: default-size instance
        n = 0;
        while (vb.busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t6 b idle", vb.busy, 0);
        @(negedge clk);
        vb.colour_muscle = 9'h092;
        cyc = 0; plots = 0; interior = 0; first_lat = -1; gaps = 0; seen_done = 0;
        first_x = 8'd0; first_y = 7'd0; last_x = 8'd0; last_y = 7'd0;
        while (seen_done == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (vb.plot === 1'b1) begin
                if (first_lat < 0) begin
                    first_lat = cyc;
                    first_x   = vb.x;
                    first_y   = vb.y;
                end
                plots++;
                if (vb.colour === 9'h092) interior++;
                last_x = vb.x;
                last_y = vb.y;
            end else if (vb.done === 1'b1) begin
                seen_done = 1;
            end else if (plots > 0) begin
                gaps++;
            end
        end
        chk("t6 done seen", seen_done, 1);
        chk("t6 latency", first_lat, 2);
        chk("t6 first x", first_x, 60);
        chk("t6 first y", first_y, 40);
        chk("t6 plots", plots, 1200);
        chk("t6 interior", interior, 816);
        chk("t6 last x", last_x, 99);
        chk("t6 last y", last_y, 69);
        chk("t6 gaps", gaps, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
